// File: rtl/ahbl_param_slave.sv
// AHB-Lite single-port memory slave with configurable bus width, memory size, base address and wait states.
// Define AHBL_PARAM_SLAVE_ERR_EN to enable ERROR responses for out-of-range, oversize or misaligned transfers.
module ahbl_param_slave #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          MEM_ADDR_WIDTH = 11,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          WAIT_STATES    = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic                  HMASTLOCK,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic [7:0]            ERR_CNT
);
    localparam int         NBYTES   = DATA_WIDTH / 8;
    localparam int         LSB      = $clog2(NBYTES);
    localparam int         AW       = MEM_ADDR_WIDTH;
    localparam int         DEPTH    = (2 ** AW) / NBYTES;
    localparam logic [2:0] MAX_SIZE = 3'(LSB);
    localparam logic [3:0] WS       = 4'(WAIT_STATES);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    function automatic logic [LSB-1:0] size_mask(input logic [2:0] size);
        logic [LSB-1:0] m;
        m = '0;
        for (int i = 0; i < LSB; i++) m[i] = (3'(i) < size);
        return m;
    endfunction

    function automatic logic [NBYTES-1:0] byte_en(input logic [LSB-1:0] lane, input logic [2:0] size);
        logic [NBYTES-1:0] m;
        m = '0;
        for (int i = 0; i < NBYTES; i++) m[i] = ((i >> size) == (int'(lane) >> size));
        return m;
    endfunction

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [2:0]            size_q, size_d;
    logic                  write_q, write_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic                  hreadyout_q, hresp_q;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    logic                  accept_s, illegal_s, wr_en_s, fwd_s, unused_s;
    logic [31:0]           off_s;
    logic [2:0]            eff_size_s;
    logic [AW-1:0]         eff_addr_s;
    logic [NBYTES-1:0]     be_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    assign accept_s   = HSEL & HREADY & HTRANS[1];
    assign off_s      = HADDR - BASE_ADDR;
    assign eff_size_s = (HSIZE > MAX_SIZE) ? MAX_SIZE : HSIZE;
    // Offset wraps into the memory and is forced down to the transfer-size alignment
    assign eff_addr_s = {off_s[AW-1:LSB], off_s[LSB-1:0] & ~size_mask(eff_size_s)};

`ifdef AHBL_PARAM_SLAVE_ERR_EN
    assign illegal_s = (off_s[31:AW] != '0) || (HSIZE > MAX_SIZE) ||
                       ((HADDR[LSB-1:0] & size_mask(HSIZE)) != '0);
    assign HRESP     = hresp_q;
    assign ERR_CNT   = err_cnt_q;
    assign unused_s  = ^{HTRANS[0], HBURST, HMASTLOCK};
`else
    assign illegal_s = 1'b0;
    assign HRESP     = 1'b0;
    assign ERR_CNT   = 8'h00;
    assign unused_s  = ^{HTRANS[0], HBURST, HMASTLOCK, off_s[31:AW], hresp_q, err_cnt_q};
`endif

    assign wr_en_s   = (state_q == ST_DATA) && write_q;
    assign be_s      = byte_en(addr_q[LSB-1:0], size_q);
    assign fwd_s     = wr_en_s && (addr_q[AW-1:LSB] == addr_d[AW-1:LSB]);
    assign HREADYOUT = hreadyout_q;
    assign HRDATA    = hrdata_q;

    // Next-state logic, address-phase capture and saturating error count
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        size_d    = size_q;
        write_d   = write_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            ST_IDLE, ST_DATA: begin
                if (accept_s) begin
                    addr_d  = eff_addr_s;
                    size_d  = eff_size_s;
                    write_d = HWRITE;
                    if (illegal_s) begin
                        state_d   = ST_ERR1;
                        err_cnt_d = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
                    end else if (WS == 4'd0) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WS;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? ST_DATA : ST_WAIT;
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read word for the coming DATA cycle, with bytes of the write committing this cycle forwarded
    always_comb begin
        rd_word_s = '0;
        for (int i = 0; i < NBYTES; i++) begin
            rd_word_s[8*i +: 8] = (fwd_s && be_s[i]) ? HWDATA[8*i +: 8]
                                                     : mem_q[addr_d[AW-1:LSB]][8*i +: 8];
        end
    end

    assign hrdata_d = ((state_d == ST_DATA) && !write_d) ? rd_word_s : '0;

    // Control state and registered bus outputs
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            size_q      <= 3'd0;
            write_q     <= 1'b0;
            err_cnt_q   <= 8'h00;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            write_q     <= write_d;
            err_cnt_q   <= err_cnt_d;
            hreadyout_q <= !((state_d == ST_WAIT) || (state_d == ST_ERR1));
            hresp_q     <= (state_d == ST_ERR1) || (state_d == ST_ERR2);
            hrdata_q    <= hrdata_d;
        end
    end

    // Byte-lane write commit in the DATA cycle; contents survive reset
    always_ff @(posedge HCLK) begin
        if (wr_en_s) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be_s[i]) mem_q[addr_q[AW-1:LSB]][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ahbl_param_slave.sv
// Bench for ahbl_param_slave: a 32-bit zero-wait instance and a 64-bit three-wait instance at base 0x1000,
// driven by a pipelined AHB master and checked against a byte-array memory model.
module tb_ahbl_param_slave;
    logic        clk = 1'b0;
    logic        hreset;
    logic        hsel0, hsel1, hwrite, hmastlock;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [63:0] hwdata;
    logic        ho0, hr0, ho1, hr1;
    logic [31:0] rd0;
    logic [63:0] rd1;
    logic [7:0]  ec0, ec1;

    always #5 clk = ~clk;

    ahbl_param_slave #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(11), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite), .HREADY(ho0),
        .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HMASTLOCK(hmastlock), .HWDATA(hwdata[31:0]),
        .HREADYOUT(ho0), .HRESP(hr0), .HRDATA(rd0), .ERR_CNT(ec0));

    ahbl_param_slave #(.DATA_WIDTH(64), .MEM_ADDR_WIDTH(11), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(3)) dut1 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel1), .HADDR(haddr), .HWRITE(hwrite), .HREADY(ho1),
        .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HMASTLOCK(hmastlock), .HWDATA(hwdata),
        .HREADYOUT(ho1), .HRESP(hr1), .HRDATA(rd1), .ERR_CNT(ec1));

`ifdef AHBL_PARAM_SLAVE_ERR_EN
    localparam logic [7:0] EC_ONE = 8'd1;
    localparam logic [7:0] EC_SAT = 8'hFF;
`else
    localparam logic [7:0] EC_ONE = 8'd0;
    localparam logic [7:0] EC_SAT = 8'd0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mm [2][2048];
    int          exp_ec [2];
    logic [31:0] bases [2];
    int          nbs [2];
    int          lsbs [2];
    int          wss [2];
    logic [63:0] last_rd;

    logic        op_wr [320];
    logic [31:0] op_addr [320];
    logic [2:0]  op_size [320];
    logic [63:0] op_wdata [320];
    int          n_ops;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_illegal(input int d, input logic [31:0] a, input logic [2:0] s);
`ifdef AHBL_PARAM_SLAVE_ERR_EN
        logic [31:0] off;
        off = a - bases[d];
        return (off >= 32'd2048) || (int'(s) > lsbs[d]) || ((a % (32'd1 << s)) != 32'd0);
`else
        return (a == 32'hFFFF_FFFF) && (s == 3'd7) && (d > 1);
`endif
    endfunction

    function automatic int eff_size(input int d, input logic [2:0] s);
        return (int'(s) > lsbs[d]) ? lsbs[d] : int'(s);
    endfunction

    function automatic int eff_off(input int d, input logic [31:0] a, input logic [2:0] s);
        int off, sz;
        off = int'((a - bases[d]) % 32'd2048);
        sz  = 1 << eff_size(d, s);
        return off - (off % sz);
    endfunction

    function automatic logic [63:0] model_read(input int d, input int off);
        logic [63:0] w;
        int wb;
        w  = '0;
        wb = off - (off % nbs[d]);
        for (int k = 0; k < nbs[d]; k++) w[8*k +: 8] = mm[d][wb + k];
        return w;
    endfunction

    task automatic model_write(input int d, input int off, input int nbytes, input logic [63:0] wd);
        for (int k = 0; k < nbytes; k++) mm[d][off + k] = wd[8*((off % nbs[d]) + k) +: 8];
    endtask

    task automatic add_op(input logic wr, input logic [31:0] a, input logic [2:0] s, input logic [63:0] wd);
        op_wr[n_ops]    = wr;
        op_addr[n_ops]  = a;
        op_size[n_ops]  = s;
        op_wdata[n_ops] = wd;
        n_ops++;
    endtask

    task automatic idle_bus();
        hsel0  = 1'b0;
        hsel1  = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr  = 32'h0;
        hsize  = 3'd0;
    endtask

    // Pipelined master: each op completes on the cycle HREADYOUT is high during its data phase
    task automatic run_ops(input int d);
        int          a_idx, d_idx, waits, cyc, off;
        bit          rdy, rsp, bad;
        logic [63:0] rd;
        a_idx = 0; d_idx = -1; waits = 0; cyc = 0;
        while ((a_idx < n_ops || d_idx >= 0) && cyc < 4000) begin
            cyc++;
            rdy    = (d == 0) ? ho0 : ho1;
            rsp    = (d == 0) ? hr0 : hr1;
            rd     = (d == 0) ? {32'h0, rd0} : rd1;
            hwdata = (d_idx >= 0 && op_wr[d_idx]) ? op_wdata[d_idx] : {$urandom, $urandom};
            if (!rdy) begin
                waits++;
                chk("hrdata_zero_in_wait", rd, 64'h0);
            end else begin
                if (d_idx >= 0) begin
                    bad = is_illegal(d, op_addr[d_idx], op_size[d_idx]);
                    off = eff_off(d, op_addr[d_idx], op_size[d_idx]);
                    chk("hresp", 64'(rsp), 64'(bad));
                    chk("wait_cycles", 64'(waits), bad ? 64'd1 : 64'(wss[d]));
                    if (!op_wr[d_idx]) begin
                        chk("hrdata", rd, bad ? 64'h0 : model_read(d, off));
                        last_rd = rd;
                    end else if (!bad) begin
                        model_write(d, off, 1 << eff_size(d, op_size[d_idx]), op_wdata[d_idx]);
                    end
                    if (bad) exp_ec[d] = (exp_ec[d] == 255) ? 255 : exp_ec[d] + 1;
                end
                waits = 0;
                if (a_idx < n_ops && !rsp) begin
                    hsel0     = (d == 0);
                    hsel1     = (d == 1);
                    htrans    = 2'b10;
                    haddr     = op_addr[a_idx];
                    hwrite    = op_wr[a_idx];
                    hsize     = op_size[a_idx];
                    hburst    = 3'($urandom_range(0, 7));
                    hmastlock = 1'($urandom_range(0, 1));
                    d_idx     = a_idx;
                    a_idx++;
                end else begin
                    idle_bus();
                    d_idx = -1;
                end
            end
            @(posedge clk); #1;
        end
        if (cyc >= 4000) chk("run_timeout", 64'd1, 64'd0);
        idle_bus();
        chk("err_cnt", (d == 0) ? 64'(ec0) : 64'(ec1), 64'(exp_ec[d]));
        n_ops = 0;
    endtask

    initial begin
        logic [63:0] old;
        int          sz, off;
        bases[0] = 32'h0000_0000; bases[1] = 32'h0000_1000;
        nbs[0] = 4;  nbs[1] = 8;
        lsbs[0] = 2; lsbs[1] = 3;
        wss[0] = 0;  wss[1] = 3;
        exp_ec[0] = 0; exp_ec[1] = 0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 2048; i++) mm[d][i] = 8'h00;
        n_ops = 0; last_rd = '0; hburst = 3'd0; hmastlock = 1'b0; hwdata = '0;
        idle_bus();
        hreset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hreadyout0", 64'(ho0), 64'd1);
        chk("rst_hresp0", 64'(hr0), 64'd0);
        chk("rst_hrdata0", 64'(rd0), 64'd0);
        chk("rst_errcnt0", 64'(ec0), 64'd0);
        chk("rst_hreadyout1", 64'(ho1), 64'd1);
        chk("rst_hresp1", 64'(hr1), 64'd0);
        chk("rst_hrdata1", rd1, 64'd0);
        chk("rst_errcnt1", 64'(ec1), 64'd0);
        hreset = 1'b0;
        @(posedge clk); #1;

        // Word write then back-to-back read of the same word
        add_op(1'b1, 32'h10, 3'd2, 64'h0000_0000_DEAD_BEEF);
        add_op(1'b0, 32'h10, 3'd2, 64'h0);
        run_ops(0);
        chk("deadbeef", last_rd, 64'h0000_0000_DEAD_BEEF);

        // Byte write to lane 3, immediately read back as a word
        add_op(1'b1, 32'h13, 3'd0, 64'h0000_0000_A55A_5A5A);
        add_op(1'b0, 32'h10, 3'd2, 64'h0);
        run_ops(0);
        chk("byte_merge", last_rd, 64'h0000_0000_A5AD_BEEF);

        // Three-wait read on the 64-bit instance
        add_op(1'b0, 32'h1008, 3'd3, 64'h0);
        run_ops(1);
        chk("ws3_read", last_rd, 64'h0);

        // Halfword write on the 64-bit bus, doubleword read of the containing word
        add_op(1'b1, 32'h1006, 3'd1, 64'h1234_9999_8888_7777);
        add_op(1'b0, 32'h1000, 3'd3, 64'h0);
        run_ops(1);
        chk("hw64", last_rd, 64'h1234_0000_0000_0000);

        // Write just past the end of memory, then saturate the error counter
        add_op(1'b1, 32'h800, 3'd2, 64'h0000_0000_1111_2222);
        add_op(1'b0, 32'h0, 3'd2, 64'h0);
        run_ops(0);
        chk("err_cnt_one", 64'(ec0), 64'(EC_ONE));
        for (int i = 0; i < 299; i++) add_op(1'b1, 32'h800, 3'd2, {$urandom, $urandom});
        run_ops(0);
        chk("err_cnt_sat", 64'(ec0), 64'(EC_SAT));

        // Random mix per instance: mostly aligned accesses in a small window, some wild ones
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 120; i++) begin
                sz  = $urandom_range(0, lsbs[d]);
                off = $urandom_range(0, 63);
                off = off - (off % (1 << sz));
                if ($urandom_range(0, 3) == 0)
                    add_op(1'($urandom_range(0, 1)), bases[d] + 32'($urandom_range(0, 4095)),
                           3'($urandom_range(0, 7)), {$urandom, $urandom});
                else
                    add_op(1'($urandom_range(0, 1)), bases[d] + 32'(off), 3'(sz), {$urandom, $urandom});
            end
            run_ops(d);
        end

        // Reset in the second wait cycle of a write must abandon it
        old    = model_read(1, 32'h20);
        hsel1  = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h1020; hsize = 3'd3;
        @(posedge clk); #1;
        idle_bus();
        hwdata = 64'hCAFE_F00D_1234_5678;
        chk("wait1_low", 64'(ho1), 64'd0);
        @(posedge clk); #1;
        chk("wait2_low", 64'(ho1), 64'd0);
        hreset = 1'b1;
        @(posedge clk); #1;
        hreset = 1'b0;
        exp_ec[0] = 0; exp_ec[1] = 0;
        chk("post_rst_hreadyout", 64'(ho1), 64'd1);
        chk("post_rst_hresp", 64'(hr1), 64'd0);
        chk("post_rst_hrdata", rd1, 64'd0);
        chk("post_rst_errcnt0", 64'(ec0), 64'd0);
        add_op(1'b0, 32'h1020, 3'd3, 64'h0);
        run_ops(1);
        chk("abandoned_write", last_rd, old);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahbl_param_slave.md
AHBL_PARAM_SLAVE -- requirements
Module: ahbl_param_slave

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the HWDATA/HRDATA width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter MEM_ADDR_WIDTH, default 11, giving the memory size of 2**MEM_ADDR_WIDTH bytes.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of memory location 0.
REQ-004 The block SHALL have parameter WAIT_STATES, default 0, giving the wait cycles per data phase; legal range is 0..15.
REQ-005 The block SHALL have port HCLK, input, width 1: the single clock.
REQ-006 The block SHALL have port HRESET, input, width 1: a synchronous, active-high reset.
REQ-007 The block SHALL have inputs HSEL (1), HADDR (32), HWRITE (1), HREADY (1), HTRANS (2), HSIZE (3), HBURST (3), HMASTLOCK (1) and HWDATA (DATA_WIDTH), all per AHB-Lite.
REQ-008 The block SHALL have outputs HREADYOUT (1), HRESP (1) and HRDATA (DATA_WIDTH).
REQ-009 The block SHALL have output ERR_CNT, width 8: a saturating count of ERROR responses issued.

Function
REQ-010 An address phase SHALL be accepted when HSEL, HREADY and HTRANS[1] are all 1; IDLE and BUSY transfers SHALL be ignored and given a zero-wait OKAY response.
REQ-011 On acceptance, the block SHALL register HADDR, HSIZE and HWRITE for the data phase.
REQ-012 The FSM SHALL have the states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-013 On an accepted legal transfer with WAIT_STATES=0, the FSM SHALL go to DATA.
REQ-014 On an accepted legal transfer with WAIT_STATES>0, the FSM SHALL go to WAIT and load a down-counter with WAIT_STATES.
REQ-015 In WAIT, HREADYOUT SHALL be 0; the counter SHALL decrement each cycle, and the FSM SHALL move to DATA when the counter reaches 1.
REQ-016 In DATA, HREADYOUT SHALL be 1 and HRESP SHALL be 0.
REQ-017 On leaving DATA, the FSM SHALL accept a pipelined address phase in the same cycle using the rules of REQ-013/REQ-014; otherwise it SHALL return to IDLE.
REQ-018 A transfer SHALL be illegal if any of the following holds: HADDR-BASE_ADDR >= 2**MEM_ADDR_WIDTH; HSIZE > log2(DATA_WIDTH/8); or HADDR is not aligned to HSIZE.
REQ-019 On an illegal transfer the FSM SHALL go directly to ERR1, with no wait states.
REQ-020 ERR1 SHALL drive HRESP=1 and HREADYOUT=0, and then move to ERR2.
REQ-021 ERR2 SHALL drive HRESP=1 and HREADYOUT=1; a pipelined address phase presented in ERR2 SHALL be ignored.
REQ-022 An illegal transfer SHALL NOT modify memory, and ERR_CNT SHALL increment on entry to ERR1, saturating at 8'hFF.
REQ-023 Writes SHALL commit in the DATA cycle, using HWDATA byte lanes selected by the registered address[log2(DATA_WIDTH/8)-1:0] and size, little-endian.
REQ-024 A read SHALL drive HRDATA with the full aligned word containing the address in the DATA cycle; HRDATA SHALL be 0 in all other states.
REQ-025 A read whose data phase immediately follows a write to the same word SHALL return the newly written bytes, with no extra wait state.
REQ-026 HBURST and HMASTLOCK SHALL be ignored; each beat SHALL be handled as a single transfer.
REQ-027 HSEL deasserted during WAIT SHALL NOT abort the transfer in progress.

Reset
REQ-028 While HRESET=1 at a rising edge of HCLK, the FSM SHALL go to IDLE, and HREADYOUT=1, HRESP=0, HRDATA=0, ERR_CNT=0, with the wait counter and registered address, size and write cleared.
REQ-029 A reset asserted during WAIT or ERR1 SHALL abandon the transfer, leaving memory unwritten.
REQ-030 Memory contents SHALL NOT be cleared by reset; simulation SHALL initialise all memory bytes to 0.

Configuration
REQ-031 When macro AHBL_PARAM_SLAVE_ERR_EN is defined, REQ-018..REQ-022 SHALL apply.
REQ-032 When AHBL_PARAM_SLAVE_ERR_EN is undefined, every transfer SHALL be treated as legal: the address SHALL wrap modulo 2**MEM_ADDR_WIDTH, a misaligned address SHALL have its low bits forced to the HSIZE alignment, HSIZE SHALL be clamped to the bus width, HRESP SHALL be tied to 0 and ERR_CNT SHALL be tied to 0.

Verification
REQ-033 With DATA_WIDTH=32 and WAIT_STATES=0: write 32'hDEADBEEF to 0x10, then read 0x10 -> HRDATA=32'hDEADBEEF in the DATA cycle, HREADYOUT held at 1 throughout.
REQ-034 With WAIT_STATES=3: a single read -> HREADYOUT=0 for exactly 3 cycles, then 1 for 1 cycle carrying the data.
REQ-035 Write byte 8'hA5 to 0x13, followed back-to-back by a word read of 0x10 -> bits [31:24]=8'hA5 and the other bytes unchanged, with no added stall.
REQ-036 With ERR_EN defined: a word write to BASE_ADDR+2**MEM_ADDR_WIDTH -> HRESP=1 with HREADYOUT 0 then 1, memory unchanged, ERR_CNT=1; 300 such writes -> ERR_CNT=8'hFF.
REQ-037 With DATA_WIDTH=64: a halfword write of 16'h1234 at 0x06 -> read 0x00 returns 64'h1234_0000_0000_0000.
REQ-038 Assert HRESET in the 2nd WAIT cycle of a write -> next cycle HREADYOUT=1, HRESP=0, and a subsequent read returns the old data.
